// File: rtl/muller_c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muller_c_pkg
// Purpose  : Shared state encoding, defaults and priority helpers for the
//            Muller C-element channel arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package muller_c_pkg;

    localparam int DEF_NUM_REQ     = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 15;
    localparam int MAX_REQ         = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_RISE   = 3'd2,
        ST_ACK_HI = 3'd3,
        ST_FALL   = 3'd4,
        ST_ACK_LO = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    // Isolates the least significant set bit (two's-complement trick).
    function automatic logic [MAX_REQ-1:0] lowest_set(input logic [MAX_REQ-1:0] v);
        return v & (~v + MAX_REQ'(1));
    endfunction

    function automatic logic [2:0] onehot_index(input logic [MAX_REQ-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muller_c_sync.sv
`default_nettype none
// ============================================================================
// Module   : muller_c_sync
// Purpose  : Reset-to-zero flop chain bringing the asynchronous C-element
//            output into the arbiter clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module muller_c_sync
    import muller_c_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/muller_c_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muller_c_channel_arbiter
// Purpose  : Round-robin arbiter sharing one Muller C-element among 4-phase
//            clients; runs a full up/down C cycle per grant, flags stuck C.
// Revision : 1.0 - initial release
// ============================================================================
module muller_c_channel_arbiter
    import muller_c_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               c_a_o,
    output logic               c_b_o,
    input  logic               c_out_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int              PTR_W    = $clog2(NUM_REQ);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 c_out_s;
    logic                 drive_hi;
    logic                 timed_out;
    logic [MAX_REQ-1:0]   req_ext, mask_ext, masked_ext, pick_ext;
    logic [NUM_REQ-1:0]   pick;
    logic [2:0]           pick_idx;
    logic [PTR_W-1:0]     ptr_next;

    muller_c_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .d_i    (c_out_i),
        .q_o    (c_out_s)
    );

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    assign req_ext    = MAX_REQ'(req_i);
    assign mask_ext   = ~((MAX_REQ'(1) << ptr_q) - MAX_REQ'(1));
    assign masked_ext = req_ext & mask_ext;
    assign pick_ext   = (|masked_ext) ? lowest_set(masked_ext) : lowest_set(req_ext);
    assign pick       = pick_ext[NUM_REQ-1:0];
    assign pick_idx   = onehot_index(pick_ext);
    assign ptr_next   = (pick_idx == 3'(NUM_REQ - 1)) ? '0 : PTR_W'(pick_idx + 3'd1);
    assign timed_out  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (|req_i) begin
                    grant_d = pick;
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                    state_d = ST_RISE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RISE: begin
                if (c_out_s) begin
                    state_d = ST_ACK_HI;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACK_HI: begin
                if (!(|(req_i & grant_q))) begin
                    cnt_d   = '0;
                    state_d = ST_FALL;
                end
            end
            ST_FALL: begin
                if (!c_out_s) begin
                    grant_d = '0;
                    state_d = ST_ACK_LO;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACK_LO: state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from flops so an async reset clears them at once.
    assign drive_hi  = (state_q == ST_RISE) || (state_q == ST_ACK_HI);
    assign c_a_o     = drive_hi;
    assign c_b_o     = drive_hi;
    assign ack_o     = (state_q == ST_ACK_HI) ? grant_q : '0;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign timeout_o = (state_q == ST_FAULT);

endmodule
`default_nettype wire
